// File: rtl/doc_mix_pkg.sv
// doc_mix_pkg: shared constants and helpers for the DOC stereo mixer.
//   SAMPLE_W  - oscillator / output sample width
//   ACC_W_DEF - default signed accumulator width
//   VOL_W_DEF - default master-volume width
//   sat_s()   - clamp a wide signed value into a w-bit signed range
package doc_mix_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int ACC_W_DEF = 21;
  localparam int VOL_W_DEF = 4;
  localparam int NUM_CH    = 2;
  localparam int WIDE_W    = 64;

  // Result stays WIDE_W bits so callers can compare it against the input
  // to detect that clamping happened.
  function automatic logic signed [WIDE_W-1:0] sat_s(input logic signed [WIDE_W-1:0] v,
                                                     input int w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction
endpackage

// File: rtl/doc_mix_chan.sv
// doc_mix_chan: one mixer channel.
//   Accumulates accepted samples (saturating at ACC_W), snapshots the sum
//   into a hold register on sync, scales hold by (master_vol+1)>>VOL_W in
//   the following cycle, and registers the 16-bit result.
// Ports:
//   clk, reset_n      - clock, async active-low reset
//   add_en, sample    - add sample to this channel's accumulator
//   sync              - end of scan: hold <= acc(+sample), acc <= 0
//   stg2_vld          - scale stage active; register result to out
//   master_vol        - volume, sampled during the scale stage
//   out               - registered channel output
//   acc_sat, out_sat  - saturation events this cycle (feed sticky clip)
// Config macro: DOC_MIXER_SAT_EN - saturate scaled output instead of wrap.
module doc_mix_chan
  import doc_mix_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int VOL_W = VOL_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       add_en,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       sync,
  input  logic                       stg2_vld,
  input  logic [VOL_W-1:0]           master_vol,
  output logic signed [SAMPLE_W-1:0] out,
  output logic                       acc_sat,
  output logic                       out_sat
);
  logic signed [ACC_W-1:0]    acc, hold, acc_next;
  logic signed [WIDE_W-1:0]   sum_w, sum_s, prod;
  logic signed [SAMPLE_W-1:0] res;
`ifdef DOC_MIXER_SAT_EN
  logic signed [WIDE_W-1:0]   scaled, scaled_s;
`endif

  always_comb begin
    sum_w    = WIDE_W'(acc) + (add_en ? WIDE_W'(sample) : '0);
    sum_s    = sat_s(sum_w, ACC_W);
    acc_sat  = (sum_s != sum_w);
    acc_next = sum_s[ACC_W-1:0];
    // Low 64 bits of the product are sign-correct regardless of operand signedness.
    prod     = WIDE_W'(hold) * (WIDE_W'(master_vol) + 64'sd1);
`ifdef DOC_MIXER_SAT_EN
    scaled   = prod >>> VOL_W;
    scaled_s = sat_s(scaled, SAMPLE_W);
    res      = scaled_s[SAMPLE_W-1:0];
    out_sat  = stg2_vld && (scaled_s != scaled);
`else
    res      = SAMPLE_W'(prod >>> VOL_W);
    out_sat  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      hold <= '0;
      out  <= '0;
    end else begin
      // A sample arriving with sync belongs to the closing frame.
      if (sync) begin
        hold <= acc_next;
        acc  <= '0;
      end else begin
        acc  <= acc_next;
      end
      if (stg2_vld) out <= res;
    end
  end
endmodule

// File: rtl/doc_stereo_mixer.sv
// doc_stereo_mixer: mixes DOC oscillator samples into a left/right frame.
// Ports:
//   clk, reset_n          - clock, async active-low reset
//   osc_en, osc_active    - sample accepted only when both are 1
//   sample_in, ca         - signed sample; ca[0] selects left(0)/right(1)
//   frame_sync            - end of scan; output appears 2 cycles later
//   master_vol            - global volume, sampled the cycle after frame_sync
//   left_out, right_out   - mixed frame samples, held between out_valid
//   out_valid             - one-cycle pulse on output update
//   clip, clip_clr        - sticky saturation flag and its clear (set wins)
// Config macro: DOC_MIXER_SAT_EN - saturate output to 16 bits and flag clip.
module doc_stereo_mixer
  import doc_mix_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int VOL_W = VOL_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       osc_en,
  input  logic                       osc_active,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic [3:0]                 ca,
  input  logic                       frame_sync,
  input  logic [VOL_W-1:0]           master_vol,
  output logic signed [SAMPLE_W-1:0] left_out,
  output logic signed [SAMPLE_W-1:0] right_out,
  output logic                       out_valid,
  output logic                       clip,
  input  logic                       clip_clr
);
  // vld_pipe[0]: scale stage active, vld_pipe[STAGES]: output registered.
  localparam int STAGES = 1;

  logic [STAGES:0]                   vld_pipe;
  logic                              accept;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]   mix_out;
  logic [NUM_CH-1:0]                 acc_sat, out_sat;

  assign accept = osc_en & osc_active;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    doc_mix_chan #(.ACC_W(ACC_W), .VOL_W(VOL_W)) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .add_en     (accept && (ca[0] == 1'(ch))),
      .sample     (sample_in),
      .sync       (frame_sync),
      .stg2_vld   (vld_pipe[0]),
      .master_vol (master_vol),
      .out        (mix_out[ch]),
      .acc_sat    (acc_sat[ch]),
      .out_sat    (out_sat[ch])
    );
  end

  assign left_out  = mix_out[0];
  assign right_out = mix_out[1];
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      clip     <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], frame_sync};
      if ((|acc_sat) || (|out_sat)) clip <= 1'b1;
      else if (clip_clr)            clip <= 1'b0;
    end
  end
endmodule

// File: tb/tb_doc_stereo_mixer.sv
// Scoreboard bench for doc_stereo_mixer: each frame_sync pushes the expected
// left/right pair and due cycle; a negedge monitor pops and compares on out_valid.
module tb_doc_stereo_mixer;
  logic               clk, reset_n, osc_en, osc_active, frame_sync, clip_clr;
  logic signed [15:0] sample_in;
  logic [3:0]         ca, master_vol;
  logic signed [15:0] left_out, right_out;
  logic               out_valid, clip;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          due;
  } exp_t;
  exp_t q[$];

`ifdef DOC_MIXER_SAT_EN
  localparam logic [15:0] EXP_2X7000 = 16'h7FFF;
  localparam logic        EXP_CLIP   = 1'b1;
  localparam logic [15:0] EXP_POSMAX = 16'h7FFF;
  localparam logic [15:0] EXP_NEGMAX = 16'h8000;
`else
  localparam logic [15:0] EXP_2X7000 = 16'hE000;
  localparam logic        EXP_CLIP   = 1'b0;
  localparam logic [15:0] EXP_POSMAX = 16'hFFFF;
  localparam logic [15:0] EXP_NEGMAX = 16'h0000;
`endif

  doc_stereo_mixer dut (
    .clk(clk), .reset_n(reset_n), .osc_en(osc_en), .osc_active(osc_active),
    .sample_in(sample_in), .ca(ca), .frame_sync(frame_sync), .master_vol(master_vol),
    .left_out(left_out), .right_out(right_out), .out_valid(out_valid),
    .clip(clip), .clip_clr(clip_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out_valid got L=%h R=%h cyc=%0d expected no output",
                 left_out, right_out, cyc);
      end else begin
        e = q.pop_front();
        if (left_out !== e.l || right_out !== e.r || cyc != e.due) begin
          miscompares++;
          $display("FAIL frame_out got L=%h R=%h cyc=%0d expected L=%h R=%h cyc=%0d",
                   left_out, right_out, cyc, e.l, e.r, e.due);
        end
      end
    end
  end

  // Bench-side reference for random frames.
  function automatic logic [15:0] mdl_out(input longint acc, input int vol);
    longint s;
    s = (acc * (vol + 1)) >>> 4;
`ifdef DOC_MIXER_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] s, input logic act, input logic [3:0] c);
    osc_en = 1'b1; osc_active = act; sample_in = s; ca = c;
    tick();
    osc_en = 1'b0; osc_active = 1'b0;
  endtask

  task automatic fs(input logic sen, input logic signed [15:0] s, input logic [3:0] c,
                    input logic [15:0] el, input logic [15:0] er);
    exp_t e;
    osc_en = sen; osc_active = sen; sample_in = s; ca = c; frame_sync = 1'b1;
    e.l = el; e.r = er; e.due = cyc + 2;
    q.push_back(e);
    tick();
    frame_sync = 1'b0; osc_en = 1'b0; osc_active = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout got %0d pending expected 0", q.size());
      q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; osc_en = 1'b0; osc_active = 1'b0; sample_in = '0; ca = '0;
    frame_sync = 1'b0; clip_clr = 1'b0; master_vol = 4'd15;
    repeat (2) tick();
    vectors += 4;
    if (left_out !== 16'h0)  begin miscompares++; $display("FAIL reset_left got %h expected 0000", left_out); end
    if (right_out !== 16'h0) begin miscompares++; $display("FAIL reset_right got %h expected 0000", right_out); end
    if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid got %b expected 0", out_valid); end
    if (clip !== 1'b0)       begin miscompares++; $display("FAIL reset_clip got %b expected 0", clip); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    master_vol = 4'd15;
    send(16'sh1000, 1'b1, 4'h0);
    fs(1'b0, '0, 4'h0, 16'h1000, 16'h0000);
    drain();
    // Output holds after the pulse.
    repeat (4) tick();
    vectors++;
    if (left_out !== 16'h1000) begin
      miscompares++; $display("FAIL hold_left got %h expected 1000", left_out);
    end
  endtask

  task automatic test_clip();
    master_vol = 4'd15;
    send(16'sh7000, 1'b1, 4'hE);
    send(16'sh7000, 1'b1, 4'h2);
    fs(1'b0, '0, 4'h0, EXP_2X7000, 16'h0000);
    drain();
    vectors++;
    if (clip !== EXP_CLIP) begin
      miscompares++; $display("FAIL clip_out_sat got %b expected %b", clip, EXP_CLIP);
    end
    clip_clr = 1'b1; tick(); clip_clr = 1'b0;
    vectors++;
    if (clip !== 1'b0) begin miscompares++; $display("FAIL clip_clr got %b expected 0", clip); end
    // Drive the left accumulator to its positive limit.
    master_vol = 4'd0;
    repeat (40) send(16'sh7FFF, 1'b1, 4'h0);
    vectors++;
    if (clip !== 1'b1) begin miscompares++; $display("FAIL clip_acc_sat got %b expected 1", clip); end
    clip_clr = 1'b1;
    send(16'sh7FFF, 1'b1, 4'h0);
    vectors++;
    if (clip !== 1'b1) begin miscompares++; $display("FAIL clip_set_wins got %b expected 1", clip); end
    tick();
    clip_clr = 1'b0;
    vectors++;
    if (clip !== 1'b0) begin miscompares++; $display("FAIL clip_clr2 got %b expected 0", clip); end
    fs(1'b0, '0, 4'h0, EXP_POSMAX, 16'h0000);
    drain();
    master_vol = 4'd15;
    repeat (40) send(-16'sh8000, 1'b1, 4'h1);
    fs(1'b0, '0, 4'h0, 16'h0000, EXP_NEGMAX);
    drain();
    clip_clr = 1'b1; tick(); clip_clr = 1'b0;
  endtask

  task automatic test_vol();
    master_vol = 4'd7;
    send(-16'sh2000, 1'b1, 4'h1);
    fs(1'b0, '0, 4'h0, 16'h0000, 16'hF000);
    drain();
    // Volume is taken in the cycle after frame_sync, not at frame_sync.
    master_vol = 4'd15;
    send(16'sh1000, 1'b1, 4'h0);
    fs(1'b0, '0, 4'h0, 16'h0400, 16'h0000);
    master_vol = 4'd3;
    drain();
    master_vol = 4'd15;
  endtask

  task automatic test_back_to_back();
    master_vol = 4'd15;
    fs(1'b1, 16'sh0100, 4'h0, 16'h0100, 16'h0000);
    fs(1'b0, '0,        4'h0, 16'h0000, 16'h0000);
    fs(1'b1, 16'sh0010, 4'h0, 16'h0010, 16'h0000);
    fs(1'b1, 16'sh0020, 4'h1, 16'h0000, 16'h0020);
    fs(1'b1, -16'sh1,   4'h0, 16'hFFFF, 16'h0000);
    drain();
  endtask

  task automatic test_inactive_and_reset();
    master_vol = 4'd15;
    send(16'sh4000, 1'b0, 4'h0);
    osc_en = 1'b0; osc_active = 1'b1; sample_in = 16'sh4000; ca = 4'h1;
    tick();
    osc_active = 1'b0;
    send(16'sh0040, 1'b1, 4'h1);
    fs(1'b0, '0, 4'h0, 16'h0000, 16'h0040);
    drain();
    send(16'sh0300, 1'b1, 4'h0);
    fs(1'b0, '0, 4'h0, 16'h0300, 16'h0000);
    drain();
    // Partial frame plus a frame in flight, then reset.
    repeat (40) send(16'sh7FFF, 1'b1, 4'h0);
    send(16'sh1000, 1'b1, 4'h1);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors += 4;
    if (left_out !== 16'h0)  begin miscompares++; $display("FAIL rst_mid_left got %h expected 0000", left_out); end
    if (right_out !== 16'h0) begin miscompares++; $display("FAIL rst_mid_right got %h expected 0000", right_out); end
    if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_mid_valid got %b expected 0", out_valid); end
    if (clip !== 1'b0)       begin miscompares++; $display("FAIL rst_mid_clip got %b expected 0", clip); end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    send(16'sh0200, 1'b1, 4'h0);
    fs(1'b0, '0, 4'h0, 16'h0200, 16'h0000);
    drain();
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      longint ml, mr;
      int vol, n, s;
      logic act;
      logic [3:0] c;
      ml = 0; mr = 0;
      vol = $urandom_range(0, 15);
      master_vol = 4'(vol);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        s = int'($urandom_range(0, 16'h1FFF)) - 16'h1000;
        act = 1'($urandom_range(0, 1));
        c = 4'($urandom_range(0, 15));
        send(16'(s), act, c);
        if (act) begin
          if (c[0]) mr += s;
          else      ml += s;
        end
      end
      fs(1'b0, '0, 4'h0, mdl_out(ml, vol), mdl_out(mr, vol));
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_vol();
    test_back_to_back();
    test_inactive_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
